// File: rtl/z80_cb_pkg.sv
// ----------------------------------------------------------------------------
// z80_cb_pkg
// Shared types and constants for the Z80 CB-prefix read-modify-write unit.
//   cb_op_t     : rotate/shift opcode (instruction bits 5:3 of CB xx)
//   cb_state_t  : sequencer states of the RMW transaction
//   FLAG_*      : bit positions inside the Z80 F register
//   is_left_op  : true for ops that shift toward the MSB
// ----------------------------------------------------------------------------
package z80_cb_pkg;

  typedef enum logic [2:0] {
    CB_RLC = 3'd0,
    CB_RRC = 3'd1,
    CB_RL  = 3'd2,
    CB_RR  = 3'd3,
    CB_SLA = 3'd4,
    CB_SRA = 3'd5,
    CB_SLL = 3'd6,
    CB_SRL = 3'd7
  } cb_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } cb_state_t;

  localparam int FLAG_C  = 0;
  localparam int FLAG_N  = 1;
  localparam int FLAG_PV = 2;
  localparam int FLAG_3  = 3;
  localparam int FLAG_H  = 4;
  localparam int FLAG_5  = 5;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_S  = 7;

  // Undocumented bits 5 and 3 pass through from the incoming flags.
  localparam logic [7:0] FLAG_XY_MASK = 8'b0010_1000;

  // Even opcodes (RLC, RL, SLA, SLL) move data toward the MSB.
  function automatic logic is_left_op(cb_op_t op);
    return (op[0] == 1'b0);
  endfunction

endpackage

// File: rtl/z80_cb_shift_alu.sv
// ----------------------------------------------------------------------------
// z80_cb_shift_alu
// Combinational rotate/shift datapath for the CB-prefix group.
//   op     : in  cb_op_t         operation to perform
//   d      : in  [DATA_W-1:0]    operand read from memory
//   f_in   : in  [7:0]           flags at instruction start (C feeds RL/RR)
//   result : out [DATA_W-1:0]    shifted/rotated value
//   flags  : out [7:0]           S Z 5 H 3 PV N C for the result
// ----------------------------------------------------------------------------
module z80_cb_shift_alu
  import z80_cb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  cb_op_t            op,
  input  logic [DATA_W-1:0] d,
  input  logic [7:0]        f_in,
  output logic [DATA_W-1:0] result,
  output logic [7:0]        flags
);

  logic shift_in;
  logic carry;

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path can leave it unassigned and infer a latch.
  always_comb begin
    shift_in = 1'b0;
    case (op)
      CB_RLC:        shift_in = d[DATA_W-1];
      CB_RRC:        shift_in = d[0];
      CB_RL, CB_RR:  shift_in = f_in[FLAG_C];
      CB_SRA:        shift_in = d[DATA_W-1];
      CB_SLL:        shift_in = 1'b1;
      default:       shift_in = 1'b0;   // SLA, SRL
    endcase

    if (is_left_op(op)) begin
      result = {d[DATA_W-2:0], shift_in};
      carry  = d[DATA_W-1];
    end else begin
      result = {shift_in, d[DATA_W-1:1]};
      carry  = d[0];
    end

    // Masking clears H and N and keeps only the pass-through bits 5 and 3.
    flags          = f_in & FLAG_XY_MASK;
    flags[FLAG_S]  = result[DATA_W-1];
    flags[FLAG_Z]  = (result == '0);
    flags[FLAG_PV] = ~^result;
    flags[FLAG_C]  = carry;
  end

endmodule

// File: rtl/z80_cb_rmw_unit.sv
// ----------------------------------------------------------------------------
// z80_cb_rmw_unit
// Executes one CB-prefix rotate/shift on a memory operand at (HL) or
// (IX/IY+d): read, compute, write back, then report flags.
//   clk, reset             : clock, synchronous active-high reset
//   start, op, base, disp  : request; ea = base (+ sign-extended disp)
//   f_in                   : flags at instruction start
//   busy, done, illegal    : status; done/illegal are one-cycle pulses
//   f_out                  : result flags, non-zero only while done=1
//   mem_rd, mem_wr         : memory requests, held until mem_ack
//   mem_addr, mem_wdata    : access address / write data (zero when idle)
//   mem_rdata, mem_ack     : read data and access completion
// ----------------------------------------------------------------------------
module z80_cb_rmw_unit
  import z80_cb_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 16,
  parameter int STRICT  = 1,
  parameter int INDEXED = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] base,
  input  logic [7:0]        disp,
  input  logic [7:0]        f_in,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [7:0]        f_out,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  cb_state_t state, state_next;

  cb_op_t            op_q;
  logic [7:0]        f_in_q;
  logic [ADDR_W-1:0] ea_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] result_q;
  logic [7:0]        flags_q;
  logic              illegal_q;

  logic [DATA_W-1:0] alu_result;
  logic [7:0]        alu_flags;
  logic [ADDR_W-1:0] disp_ext;
  logic [ADDR_W-1:0] ea_calc;
  logic              reject;
  logic              accept;

  // Displacement is two's complement; the add wraps at 2^ADDR_W.
  assign disp_ext = ADDR_W'($signed(disp));
  assign ea_calc  = (INDEXED != 0) ? base + disp_ext : base;

  assign reject = (STRICT != 0) && (cb_op_t'(op) == CB_SLL);
  assign accept = (state == ST_IDLE) && start && !reject;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic. mem_ack only matters in READ and WRITE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept)  state_next = ST_READ;
      ST_READ:  if (mem_ack) state_next = ST_EXEC;
      ST_EXEC:               state_next = ST_WRITE;
      ST_WRITE: if (mem_ack) state_next = ST_DONE;
      ST_DONE:               state_next = ST_IDLE;
      default:               state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from state, so reset alone zeroes them all.
  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    mem_rd    = (state == ST_READ);
    mem_wr    = (state == ST_WRITE);
    mem_addr  = (mem_rd || mem_wr) ? ea_q : '0;
    mem_wdata = mem_wr ? result_q : '0;
    f_out     = done ? flags_q : '0;
    illegal   = illegal_q;
  end

  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= (state == ST_IDLE) && start && reject;
  end

  // NOTE: datapath registers carry no reset; they are loaded before use and
  // every output that exposes them is gated by the state decode above.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= cb_op_t'(op);
      f_in_q <= f_in;
      ea_q   <= ea_calc;
    end
    if (state == ST_READ && mem_ack) data_q <= mem_rdata;
    if (state == ST_EXEC) begin
      result_q <= alu_result;
      flags_q  <= alu_flags;
    end
  end

  z80_cb_shift_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op_q),
    .d      (data_q),
    .f_in   (f_in_q),
    .result (alu_result),
    .flags  (alu_flags)
  );

endmodule

// File: tb/tb_z80_cb_rmw_unit.sv
// ----------------------------------------------------------------------------
// tb_z80_cb_rmw_unit
// Directed bench for z80_cb_rmw_unit. Two instances share the stimulus:
// u_strict (defaults) and u_loose (STRICT=0, INDEXED=0). sel_ns picks which
// one receives start and whose outputs are observed. Expected values are
// hand-computed constants.
// ----------------------------------------------------------------------------
module tb_z80_cb_rmw_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [15:0] base;
  logic [7:0]  disp;
  logic [7:0]  f_in;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        sel_ns;

  logic        s_busy, s_done, s_illegal, s_mem_rd, s_mem_wr;
  logic [7:0]  s_f_out, s_mem_wdata;
  logic [15:0] s_mem_addr;
  logic        n_busy, n_done, n_illegal, n_mem_rd, n_mem_wr;
  logic [7:0]  n_f_out, n_mem_wdata;
  logic [15:0] n_mem_addr;

  logic        o_busy, o_done, o_illegal, o_mem_rd, o_mem_wr;
  logic [7:0]  o_f_out, o_mem_wdata;
  logic [15:0] o_mem_addr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  z80_cb_rmw_unit u_strict (
    .clk(clk), .reset(reset), .start(start && !sel_ns), .op(op),
    .base(base), .disp(disp), .f_in(f_in),
    .busy(s_busy), .done(s_done), .illegal(s_illegal), .f_out(s_f_out),
    .mem_rd(s_mem_rd), .mem_wr(s_mem_wr), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  z80_cb_rmw_unit #(.STRICT(0), .INDEXED(0)) u_loose (
    .clk(clk), .reset(reset), .start(start && sel_ns), .op(op),
    .base(base), .disp(disp), .f_in(f_in),
    .busy(n_busy), .done(n_done), .illegal(n_illegal), .f_out(n_f_out),
    .mem_rd(n_mem_rd), .mem_wr(n_mem_wr), .mem_addr(n_mem_addr),
    .mem_wdata(n_mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always_comb begin
    o_busy      = sel_ns ? n_busy      : s_busy;
    o_done      = sel_ns ? n_done      : s_done;
    o_illegal   = sel_ns ? n_illegal   : s_illegal;
    o_mem_rd    = sel_ns ? n_mem_rd    : s_mem_rd;
    o_mem_wr    = sel_ns ? n_mem_wr    : s_mem_wr;
    o_mem_addr  = sel_ns ? n_mem_addr  : s_mem_addr;
    o_mem_wdata = sel_ns ? n_mem_wdata : s_mem_wdata;
    o_f_out     = sel_ns ? n_f_out     : s_f_out;
  end

  // Shift-op table: op, f_in, read data, expected write data, expected flags.
  logic [2:0] t_op   [9] = '{3'd5, 3'd2, 3'd4, 3'd0, 3'd1, 3'd3, 3'd3, 3'd7, 3'd5};
  logic [7:0] t_f    [9] = '{8'h28, 8'h01, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
  logic [7:0] t_rd   [9] = '{8'h81, 8'h80, 8'h80, 8'h85, 8'h01, 8'h02, 8'h00, 8'hFF, 8'h7E};
  logic [7:0] t_wd   [9] = '{8'hC0, 8'h01, 8'h00, 8'h0B, 8'h80, 8'h01, 8'h80, 8'h7F, 8'h3F};
  logic [7:0] t_fo   [9] = '{8'hAD, 8'h01, 8'h45, 8'h29, 8'h81, 8'h00, 8'h80, 8'h01, 8'h04};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction acting as memory. Acks a read on its (rd_dly+1)th
  // request cycle and a write on its (wr_dly+1)th. clean drops if requests
  // overlap or change while held. done_cyc counts edges from the start edge;
  // -1 means no done within the budget.
  task automatic do_op(input logic ns, input logic [2:0] o, input logic [15:0] b,
                       input logic [7:0] d, input logic [7:0] f, input logic [7:0] rd,
                       input int rd_dly, input int wr_dly, input logic noise,
                       output logic [15:0] rd_addr, output logic [15:0] wr_addr,
                       output logic [7:0] wdata, output logic [7:0] fout,
                       output int done_cyc, output logic clean);
    int rd_cnt = 0;
    int wr_cnt = 0;
    rd_addr = '0; wr_addr = '0; wdata = '0; fout = '0;
    done_cyc = -1; clean = 1'b1;
    sel_ns = ns; op = o; base = b; disp = d; f_in = f;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      mem_ack = 1'b0;
      mem_rdata = 8'h5A;
      if (o_mem_rd && o_mem_wr) clean = 1'b0;
      if (o_done) begin
        done_cyc = cyc;
        fout = o_f_out;
        break;
      end
      if (o_mem_rd) begin
        rd_cnt++;
        if (rd_cnt == 1) rd_addr = o_mem_addr;
        else if (o_mem_addr !== rd_addr) clean = 1'b0;
        if (rd_cnt == rd_dly + 1) begin
          mem_ack = 1'b1;
          mem_rdata = rd;
        end
      end
      if (o_mem_wr) begin
        wr_cnt++;
        if (wr_cnt == 1) begin
          wr_addr = o_mem_addr;
          wdata = o_mem_wdata;
        end else if (o_mem_addr !== wr_addr || o_mem_wdata !== wdata) clean = 1'b0;
        if (wr_cnt == wr_dly + 1) mem_ack = 1'b1;
      end
      if (noise && o_busy) begin
        start = 1'b1; op = 3'd0; base = 16'hAAAA; disp = 8'h40; f_in = 8'hFF;
      end
      tick();
    end
    mem_ack = 1'b0;
    start = 1'b0;
    if (done_cyc > 0) tick();
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; op = 3'd0; sel_ns = 1'b0;
    tick();
    tick();
    start = 1'b0;
    reset = 1'b0;
    vectors++;
    if ({o_busy, o_done, o_illegal, o_mem_rd, o_mem_wr} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b want 00000", {o_busy, o_done, o_illegal, o_mem_rd, o_mem_wr});
    end
    vectors++;
    if ({o_mem_addr, o_mem_wdata, o_f_out} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_bus: got %h want 00000000", {o_mem_addr, o_mem_wdata, o_f_out});
    end
    tick();
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy got %b want 0", o_busy);
    end
  endtask

  task automatic test_shift_ops;
    logic [15:0] ra, wa;
    logic [7:0]  wd, fo;
    int          dc;
    logic        cl;
    for (int i = 0; i < 9; i++) begin
      do_op(1'b0, t_op[i], 16'h4000 + 16'(i), 8'h00, t_f[i], t_rd[i], 0, 0, 1'b0,
            ra, wa, wd, fo, dc, cl);
      vectors++;
      if (wd !== t_wd[i]) begin
        miscompares++;
        $display("FAIL op%0d_wdata: got %h want %h", i, wd, t_wd[i]);
      end
      vectors++;
      if (fo !== t_fo[i]) begin
        miscompares++;
        $display("FAIL op%0d_flags: got %h want %h", i, fo, t_fo[i]);
      end
      vectors++;
      if (dc !== 4 || !cl || ra !== 16'h4000 + 16'(i) || wa !== ra) begin
        miscompares++;
        $display("FAIL op%0d_bus: done_cyc %0d clean %b rd %h wr %h want 4 1 %h", i, dc, cl, ra, wa,
                 16'h4000 + 16'(i));
      end
    end
  endtask

  task automatic test_indexed;
    logic [15:0] ra, wa;
    logic [7:0]  wd, fo;
    int          dc;
    logic        cl;
    do_op(1'b0, 3'd7, 16'h1000, 8'hFE, 8'h00, 8'h10, 0, 0, 1'b0, ra, wa, wd, fo, dc, cl);
    vectors++;
    if (ra !== 16'h0FFE || wa !== 16'h0FFE) begin
      miscompares++;
      $display("FAIL idx_neg: rd %h wr %h want 0ffe", ra, wa);
    end
    do_op(1'b0, 3'd7, 16'hFFFF, 8'h01, 8'h00, 8'h10, 0, 0, 1'b0, ra, wa, wd, fo, dc, cl);
    vectors++;
    if (ra !== 16'h0000 || wa !== 16'h0000) begin
      miscompares++;
      $display("FAIL idx_wrap: rd %h wr %h want 0000", ra, wa);
    end
    do_op(1'b0, 3'd7, 16'h1000, 8'h7F, 8'h00, 8'h10, 0, 0, 1'b0, ra, wa, wd, fo, dc, cl);
    vectors++;
    if (ra !== 16'h107F) begin
      miscompares++;
      $display("FAIL idx_pos: rd %h want 107f", ra);
    end
  endtask

  task automatic test_illegal;
    sel_ns = 1'b0; op = 3'd6; base = 16'h1234; disp = 8'h00; f_in = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (o_illegal !== 1'b1 || o_busy !== 1'b0 || o_mem_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL sll_reject: illegal %b busy %b rd %b want 1 0 0", o_illegal, o_busy, o_mem_rd);
    end
    // A stray ack while idle must not start anything.
    mem_ack = 1'b1;
    mem_rdata = 8'hEE;
    tick();
    mem_ack = 1'b0;
    vectors++;
    if (o_illegal !== 1'b0 || o_busy !== 1'b0 || o_mem_rd !== 1'b0 || o_mem_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL sll_after: illegal %b busy %b rd %b wr %b want 0 0 0 0",
               o_illegal, o_busy, o_mem_rd, o_mem_wr);
    end
  endtask

  task automatic test_sll_loose;
    logic [15:0] ra, wa;
    logic [7:0]  wd, fo;
    int          dc;
    logic        cl;
    // INDEXED=0 instance: disp must not affect the address.
    do_op(1'b1, 3'd6, 16'h2000, 8'h10, 8'h00, 8'h00, 0, 0, 1'b0, ra, wa, wd, fo, dc, cl);
    vectors++;
    if (wd !== 8'h01 || fo !== 8'h00) begin
      miscompares++;
      $display("FAIL sll_loose: wdata %h flags %h want 01 00", wd, fo);
    end
    vectors++;
    if (ra !== 16'h2000 || dc !== 4) begin
      miscompares++;
      $display("FAIL noidx_addr: rd %h done_cyc %0d want 2000 4", ra, dc);
    end
    sel_ns = 1'b0;
  endtask

  task automatic test_wait_states;
    logic [15:0] ra, wa;
    logic [7:0]  wd, fo;
    int          dc;
    logic        cl;
    do_op(1'b0, 3'd7, 16'h5555, 8'h00, 8'h08, 8'h81, 3, 2, 1'b1, ra, wa, wd, fo, dc, cl);
    vectors++;
    if (dc !== 9) begin
      miscompares++;
      $display("FAIL wait_latency: done_cyc %0d want 9", dc);
    end
    vectors++;
    if (!cl || ra !== 16'h5555 || wa !== 16'h5555) begin
      miscompares++;
      $display("FAIL wait_stable: clean %b rd %h wr %h want 1 5555", cl, ra, wa);
    end
    vectors++;
    if (wd !== 8'h40 || fo !== 8'h09) begin
      miscompares++;
      $display("FAIL wait_result: wdata %h flags %h want 40 09", wd, fo);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] ra, wa;
    logic [7:0]  wd, fo;
    int          dc;
    logic        cl;
    do_op(1'b0, 3'd4, 16'h0100, 8'h00, 8'h00, 8'h01, 0, 0, 1'b0, ra, wa, wd, fo, dc, cl);
    vectors++;
    if (wd !== 8'h02 || fo !== 8'h00 || dc !== 4) begin
      miscompares++;
      $display("FAIL b2b_first: wdata %h flags %h cyc %0d want 02 00 4", wd, fo, dc);
    end
    do_op(1'b0, 3'd0, 16'h0101, 8'h00, 8'h00, 8'hFF, 0, 0, 1'b0, ra, wa, wd, fo, dc, cl);
    vectors++;
    if (wd !== 8'hFF || fo !== 8'h85 || dc !== 4) begin
      miscompares++;
      $display("FAIL b2b_second: wdata %h flags %h cyc %0d want ff 85 4", wd, fo, dc);
    end
  endtask

  task automatic test_reset_mid_write;
    logic bad = 1'b0;
    sel_ns = 1'b0; op = 3'd7; base = 16'h3000; disp = 8'h00; f_in = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 8'h22;
    tick();
    mem_ack = 1'b0;
    tick();
    vectors++;
    if (o_mem_wr !== 1'b1 || o_mem_addr !== 16'h3000) begin
      miscompares++;
      $display("FAIL rst_setup: wr %b addr %h want 1 3000", o_mem_wr, o_mem_addr);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (o_mem_wr !== 1'b0 || o_busy !== 1'b0 || o_mem_addr !== 16'h0) begin
      miscompares++;
      $display("FAIL rst_abort: wr %b busy %b addr %h want 0 0 0000", o_mem_wr, o_busy, o_mem_addr);
    end
    for (int i = 0; i < 8; i++) begin
      if (o_done || o_mem_wr || o_busy) bad = 1'b1;
      tick();
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL rst_quiet: activity after reset got 1 want 0");
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = '0; base = '0; disp = '0; f_in = '0;
    mem_rdata = '0; mem_ack = 1'b0; sel_ns = 1'b0;
    test_reset();
    test_shift_ops();
    test_indexed();
    test_illegal();
    test_sll_loose();
    test_wait_states();
    test_back_to_back();
    test_reset_mid_write();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
